// File: rtl/sfifo_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sfifo_gen_pkg
//  Description : Shared constants and pointer helpers for the sfifo_gen FIFO.
//                Holds the default configuration, a pointer-difference
//                function returning the fill level and a full/empty compare
//                on (ADDR_W+1)-bit pointers carried in a fixed-width container.
//  Revision    : 1.0 - initial release
// ============================================================================
package sfifo_gen_pkg;

   localparam int unsigned C_DATA_W    = 8;
   localparam int unsigned C_ADDR_W    = 4;
   localparam int unsigned C_AF_LEVEL  = 12;
   localparam int unsigned C_AE_LEVEL  = 2;

   // Pointers are zero-extended into this container so one function body
   // serves every ADDR_W (ADDR_W must stay below PTR_MAX_W-1).
   localparam int unsigned PTR_MAX_W   = 32;

   typedef logic [PTR_MAX_W-1:0] ptr_t;

   typedef struct packed {
      logic full;
      logic empty;
   } ptr_status_t;

   // Fill level = (wptr - rptr) modulo 2**(aw+1).
   function automatic ptr_t ptr_count(input ptr_t wptr, input ptr_t rptr,
                                      input int unsigned aw);
      ptr_t mask;
      mask = (ptr_t'(1) << (aw + 1)) - ptr_t'(1);
      return (wptr - rptr) & mask;
   endfunction

   // Full when the wrap bits differ and the address bits match.
   function automatic ptr_status_t ptr_cmp(input ptr_t wptr, input ptr_t rptr,
                                           input int unsigned aw);
      ptr_status_t s;
      ptr_t        mask;
      ptr_t        msb;
      mask    = (ptr_t'(1) << (aw + 1)) - ptr_t'(1);
      msb     = ptr_t'(1) << aw;
      s.empty = ((wptr & mask) == (rptr & mask));
      s.full  = (((wptr ^ rptr) & mask) == msb);
      return s;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sfifo_gen_mem.sv
`default_nettype none
// ============================================================================
//  Module      : sfifo_gen_mem
//  Description : DEPTH x DATA_W register array, one synchronous write port
//                and one asynchronous read port. Contents are not reset.
//  Ports       : clk      - clock
//                we_i     - write enable
//                waddr_i  - write address
//                wdata_i  - write data
//                raddr_i  - read address
//                rdata_o  - read data (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
module sfifo_gen_mem
   import sfifo_gen_pkg::*;
#(
   parameter int unsigned DATA_W = C_DATA_W,
   parameter int unsigned ADDR_W = C_ADDR_W
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/sfifo_gen.sv
`default_nettype none
// ============================================================================
//  Module      : sfifo_gen
//  Description : Parametrised single-clock FIFO with fill count, programmable
//                almost-full/almost-empty flags, sticky overflow/underflow and
//                synchronous flush.
//                Compile option SFIFO_GEN_FWFT_EN selects first-word-fall-
//                through reads; without it rd_data is registered (1-cycle
//                latency, rd_valid pulses once per accepted read).
//  Ports       : clk, rst (sync, active-high), flush (sync clear)
//                wr_en/wr_data - write request and word
//                rd_en         - read request (pop)
//                rd_data/rd_valid - read word and its qualifier
//                empty, full, almost_full, almost_empty, count - status
//                overflow, underflow - sticky error flags
//  Revision    : 1.0 - initial release
// ============================================================================
module sfifo_gen
   import sfifo_gen_pkg::*;
#(
   parameter int unsigned DATA_W   = C_DATA_W,
   parameter int unsigned ADDR_W   = C_ADDR_W,
   parameter int unsigned AF_LEVEL = C_AF_LEVEL,
   parameter int unsigned AE_LEVEL = C_AE_LEVEL
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              empty,
   output logic              full,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic              underflow
);

   localparam int unsigned PTR_W = ADDR_W + 1;

   logic [PTR_W-1:0]  wptr_q, wptr_d;
   logic [PTR_W-1:0]  rptr_q, rptr_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;
   logic              wr_acc, rd_acc;
   logic [DATA_W-1:0] mem_rdata;
   ptr_t              level;
   ptr_status_t       status;

   // Status is purely a function of the registered pointers.
   assign level        = ptr_count(ptr_t'(wptr_q), ptr_t'(rptr_q), ADDR_W);
   assign status       = ptr_cmp(ptr_t'(wptr_q), ptr_t'(rptr_q), ADDR_W);
   assign empty        = status.empty;
   assign full         = status.full;
   assign count        = level[ADDR_W:0];
   assign almost_full  = (level >= ptr_t'(AF_LEVEL));
   assign almost_empty = (level <= ptr_t'(AE_LEVEL));
   assign overflow     = ovf_q;
   assign underflow    = unf_q;

   // A write into a full FIFO is allowed when a read frees a slot in the
   // same cycle; a read of an empty FIFO is never bypassed from wr_data.
   assign rd_acc = rd_en & ~empty;
   assign wr_acc = wr_en & (~full | rd_acc);

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      ovf_d  = ovf_q | (wr_en & ~wr_acc);
      unf_d  = unf_q | (rd_en & empty);
      if (wr_acc) begin
         wptr_d = wptr_q + PTR_W'(1);
      end
      if (rd_acc) begin
         rptr_d = rptr_q + PTR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wptr_q <= '0;
         rptr_q <= '0;
         ovf_q  <= 1'b0;
         unf_q  <= 1'b0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         ovf_q  <= ovf_d;
         unf_q  <= unf_d;
      end
   end

   sfifo_gen_mem #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk     (clk),
      .we_i    (wr_acc & ~rst & ~flush),
      .waddr_i (wptr_q[ADDR_W-1:0]),
      .wdata_i (wr_data),
      .raddr_i (rptr_q[ADDR_W-1:0]),
      .rdata_o (mem_rdata)
   );

`ifdef SFIFO_GEN_FWFT_EN
   // Head word is always on the output; it is valid whenever not empty.
   assign rd_data  = mem_rdata;
   assign rd_valid = ~empty;
`else
   logic [DATA_W-1:0] rd_data_q;
   logic              rd_valid_q;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= rd_acc;
         if (rd_acc) begin
            rd_data_q <= mem_rdata;
         end
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
`endif

endmodule
`default_nettype wire
